// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-byte holding buffer; tx falls one edge after a byte is accepted in IDLE.
// Backpressure: tx_ready_o is low while the holding buffer is full, and a tx_valid_i seen while it is low is ignored.
module uart_tx #(
  parameter int unsigned BAUD_DIV  = 104,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] CNT_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        tx_q, tx_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        accept, unload, baud_tick;

  assign accept    = tx_valid_i && tx_ready_q;
  assign baud_tick = (cnt_q == 16'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    unload     = 1'b0;

    if (accept) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end

    if (!baud_tick && state_q != IDLE) begin
      cnt_d = cnt_q - 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          state_d = START;
          unload  = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        // bit_idx doubles as the stop-bit counter so the 16-bit counter never needs STOP_BITS*BAUD_DIV
        if (baud_tick) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = 3'd0;
            if (buf_full_q) begin
              state_d = START;
              unload  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            cnt_d     = CNT_RELOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (unload) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      cnt_d      = CNT_RELOAD;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d != IDLE) || buf_full_d;
    tx_ready_d = !buf_full_d;
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = tx_ready_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (BAUD_DIV/STOP_BITS = 4/1, 2/2, 2/1) selected by sel.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [1:0] sel;
  logic [2:0] vld, rdy_w, tx_w, busy_w;
  logic       tx_m, rdy_m, busy_m;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  assign vld    = tx_valid ? (3'b001 << sel) : 3'b000;
  assign tx_m   = tx_w[sel];
  assign rdy_m  = rdy_w[sel];
  assign busy_m = busy_w[sel];

  uart_tx #(.BAUD_DIV(4), .STOP_BITS(1)) u_bd4 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(vld[0]),
    .tx_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]));
  uart_tx #(.BAUD_DIV(2), .STOP_BITS(2)) u_bd2_sb2 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(vld[1]),
    .tx_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]));
  uart_tx #(.BAUD_DIV(2), .STOP_BITS(1)) u_bd2 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(vld[2]),
    .tx_ready_o(rdy_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]));

  // Expected line level per cycle, index 0 = first cycle after the accepting edge's successor.
  function automatic logic [255:0] frame_bits(input logic [7:0] d, input int bd, input int sb);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < (9 + sb) * bd; i++) begin
      int k;
      k = i / bd;
      v[i] = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b1;
    end
    return v;
  endfunction

  function automatic logic [255:0] ones(input int n);
    return (256'd1 << n) - 256'd1;
  endfunction

  task automatic send(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic capture(input int n, output logic [255:0] tv, output logic [255:0] bv);
    tv = '0;
    bv = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tv[i] = tx_m;
      bv[i] = busy_m;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tx_w !== 3'b111) $display("FAIL reset_tx: got %b want 111", tx_w); else n_pass++;
    n_checks++; if (rdy_w !== 3'b000) $display("FAIL reset_ready: got %b want 000", rdy_w); else n_pass++;
    n_checks++; if (busy_w !== 3'b000) $display("FAIL reset_busy: got %b want 000", busy_w); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rdy_w !== 3'b111) $display("FAIL reset_release_ready: got %b want 111", rdy_w); else n_pass++;
  endtask

  task automatic test_single;
    logic [255:0] tv, bv;
    sel = 2'd0;
    n_checks++; if (rdy_m !== 1'b1) $display("FAIL single_ready_idle: got %b want 1", rdy_m); else n_pass++;
    send(8'h55);
    n_checks++; if (tx_m !== 1'b1) $display("FAIL single_tx_at_accept: got %b want 1", tx_m); else n_pass++;
    n_checks++; if (rdy_m !== 1'b0) $display("FAIL single_ready_full: got %b want 0", rdy_m); else n_pass++;
    n_checks++; if (busy_m !== 1'b1) $display("FAIL single_busy_at_accept: got %b want 1", busy_m); else n_pass++;
    capture(40, tv, bv);
    n_checks++; if (tv !== frame_bits(8'h55, 4, 1)) $display("FAIL single_frame: got %h want %h", tv, frame_bits(8'h55, 4, 1)); else n_pass++;
    n_checks++; if (bv !== ones(40)) $display("FAIL single_busy_frame: got %h want %h", bv, ones(40)); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy_m); else n_pass++;
    n_checks++; if (tx_m !== 1'b1) $display("FAIL single_tx_idle: got %b want 1", tx_m); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [255:0] tv, bv, exp;
    sel = 2'd0;
    exp = frame_bits(8'hA5, 4, 1) | (frame_bits(8'h3C, 4, 1) << 40);
    send(8'hA5);
    fork
      capture(80, tv, bv);
      begin
        @(posedge clk); #1;
        n_checks++; if (rdy_m !== 1'b1) $display("FAIL b2b_ready_after_unload: got %b want 1", rdy_m); else n_pass++;
        send(8'h3C);
        n_checks++; if (rdy_m !== 1'b0) $display("FAIL b2b_ready_refull: got %b want 0", rdy_m); else n_pass++;
      end
    join
    n_checks++; if (tv !== exp) $display("FAIL b2b_frames: got %h want %h", tv, exp); else n_pass++;
    n_checks++; if (bv !== ones(80)) $display("FAIL b2b_busy: got %h want %h", bv, ones(80)); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy_m); else n_pass++;
  endtask

  task automatic test_hold_valid;
    logic [199:0] cap;
    logic [7:0]   acc [8];
    logic [7:0]   dec [8];
    int           n_acc, n_dec, i;
    sel   = 2'd0;
    n_acc = 0;
    n_dec = 0;
    for (int c = 0; c < 200; c++) begin
      tx_valid = (n_acc < 3);
      tx_data  = 8'(c * 37 + 5);
      if (tx_valid && rdy_m) begin
        acc[n_acc] = tx_data;
        n_acc++;
      end
      @(posedge clk); #1;
      cap[c] = tx_m;
    end
    tx_valid = 1'b0;
    i = 0;
    while (i < 200 - 40) begin
      if (cap[i] == 1'b0 && n_dec < 8) begin
        for (int b = 0; b < 8; b++) dec[n_dec][b] = cap[i + 4 + 4 * b + 2];
        n_dec++;
        i += 40;
      end else begin
        i++;
      end
    end
    n_checks++; if (n_acc != 3) $display("FAIL hold_accept_count: got %0d want 3", n_acc); else n_pass++;
    n_checks++; if (n_dec != n_acc) $display("FAIL hold_frame_count: got %0d want %0d", n_dec, n_acc); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (dec[k] !== acc[k]) $display("FAIL hold_byte%0d: got %h want %h", k, dec[k], acc[k]); else n_pass++;
    end
    n_checks++; if (busy_m !== 1'b0) $display("FAIL hold_busy_end: got %b want 0", busy_m); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int zeros, busy_hi;
    sel = 2'd0;
    send(8'hFF);
    @(posedge clk); #1;
    send(8'h00);
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (tx_m !== 1'b1) $display("FAIL rstmid_bit3: got %b want 1", tx_m); else n_pass++;
    n_checks++; if (busy_m !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy_m); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (tx_m !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", tx_m); else n_pass++;
    n_checks++; if (rdy_m !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", rdy_m); else n_pass++;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_m); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rdy_m !== 1'b1) $display("FAIL rstmid_ready_release: got %b want 1", rdy_m); else n_pass++;
    zeros   = 0;
    busy_hi = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tx_m !== 1'b1) zeros++;
      if (busy_m !== 1'b0) busy_hi++;
    end
    n_checks++; if (zeros != 0) $display("FAIL rstmid_no_frame: got %0d low cycles want 0", zeros); else n_pass++;
    n_checks++; if (busy_hi != 0) $display("FAIL rstmid_idle_busy: got %0d busy cycles want 0", busy_hi); else n_pass++;
  endtask

  task automatic test_stop2;
    logic [255:0] tv, bv;
    sel = 2'd1;
    n_checks++; if (rdy_m !== 1'b1) $display("FAIL stop2_ready: got %b want 1", rdy_m); else n_pass++;
    send(8'h00);
    capture(22, tv, bv);
    n_checks++; if (tv !== frame_bits(8'h00, 2, 2)) $display("FAIL stop2_frame: got %h want %h", tv, frame_bits(8'h00, 2, 2)); else n_pass++;
    n_checks++; if (bv !== ones(22)) $display("FAIL stop2_busy: got %h want %h", bv, ones(22)); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL stop2_busy_end: got %b want 0", busy_m); else n_pass++;
  endtask

  task automatic test_min_baud;
    logic [255:0] tv, bv;
    sel = 2'd2;
    n_checks++; if (rdy_m !== 1'b1) $display("FAIL minbaud_ready: got %b want 1", rdy_m); else n_pass++;
    send(8'h81);
    capture(20, tv, bv);
    n_checks++; if (tv !== frame_bits(8'h81, 2, 1)) $display("FAIL minbaud_frame: got %h want %h", tv, frame_bits(8'h81, 2, 1)); else n_pass++;
    n_checks++; if (bv !== ones(20)) $display("FAIL minbaud_busy: got %h want %h", bv, ones(20)); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL minbaud_busy_end: got %b want 0", busy_m); else n_pass++;
    n_checks++; if (tx_m !== 1'b1) $display("FAIL minbaud_tx_idle: got %b want 1", tx_m); else n_pass++;
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    sel      = 2'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_valid();
    test_reset_midframe();
    test_stop2();
    test_min_baud();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
